axis_frame_gen: RTL and testbench
=================================

# axis_frame_gen

AXI-Stream frame transmitter that produces framed test traffic for the `s_axis_*` slave port of the stream FIFO. On a start pulse it emits one frame of `frame_len` beats carrying an incrementing data pattern from a programmable seed. It asserts `m_axis_last` on the final beat and then holds off for a programmable inter-frame gap. It honours backpressure with full AXI-Stream valid/ready rules and reports completion and a running frame count.

## Interface
- `DATA_WIDTH`, 32, beat data width.
- `LEN_WIDTH`, 12, width of the frame length and beat counter; the maximum frame is 2^LEN_WIDTH−1 beats.
- `GAP_WIDTH`, 8, width of the inter-frame gap count.
- `clk` in 1 — single clock; all logic is on its rising edge.
- `reset_n` in 1 — reset; asynchronous and active-high (asserted = 1) despite the name.
- `start` in 1 — request one frame; sampled only in IDLE.
- `frame_len` in LEN_WIDTH — beats per frame; sampled with `start`.
- `seed` in DATA_WIDTH — data value of beat 0; sampled with `start`.
- `gap_cycles` in GAP_WIDTH — idle cycles after the last beat; sampled with `start`.
- `m_axis_data` out DATA_WIDTH — beat payload.
- `m_axis_valid` out 1 — beat valid.
- `m_axis_ready` in 1 — downstream ready.
- `m_axis_last` out 1 — final beat of the frame.
- `busy` out 1 — high in SEND or GAP.
- `done` out 1 — one-cycle pulse after the last beat is accepted.
- `frame_cnt` out 16 — number of completed frames; wraps modulo 2^16.

## Operation
- FSM states: IDLE, SEND, GAP. Reset state is IDLE.
- IDLE → SEND when `start`=1 and `frame_len`≠0:
  - latch `frame_len`, `gap_cycles`;
  - load `m_axis_data`=`seed`;
  - clear the beat counter;
  - set `m_axis_valid`=1;
  - set `m_axis_last`=1 when `frame_len`==1.
- `start` with `frame_len`==0 is ignored: no state change, no `done`.
- In SEND, a beat transfers on `m_axis_valid` && `m_axis_ready`. On each transfer:
  - the beat counter increments;
  - `m_axis_data` increments by 1, modulo 2^DATA_WIDTH (0xFFFFFFFF → 0x00000000);
  - `m_axis_last` is set high for the beat whose index is `frame_len`−1.
- Transfer of the beat with `m_axis_last`=1:
  - clears `m_axis_valid` and `m_axis_last`;
  - pulses `done`;
  - increments `frame_cnt`;
  - moves to GAP if the latched gap ≠0, otherwise to IDLE.
- GAP counts the latched gap down to 0, then moves to IDLE. `m_axis_valid`=0 throughout GAP.
- `start` in SEND or GAP is ignored (not queued).
- AXI rule: once `m_axis_valid` is high, `m_axis_valid`, `m_axis_data` and `m_axis_last` are held stable until the transfer completes. `m_axis_valid` never depends combinationally on `m_axis_ready`.
- `busy` = (state ≠ IDLE).

## Timing
- All outputs are registered.
- Reset values: `m_axis_data`=0, `m_axis_valid`=0, `m_axis_last`=0, `busy`=0, `done`=0, `frame_cnt`=0, state IDLE.
- Reset mid-frame: outputs clear immediately (asynchronous). The partial frame is abandoned, with no `done` and no count increment.
- Start latency: `start` sampled at edge N gives `m_axis_valid`=1 and `busy`=1 after edge N.
- Throughput with `m_axis_ready` held at 1: one beat per cycle, and the frame occupies exactly `frame_len` consecutive cycles.
- `done` is high for the one cycle after the edge that accepts the last beat.
- IDLE-to-next-valid spacing after the last-beat edge is `gap_cycles` + 1 cycles minimum. That is the GAP cycles plus one IDLE cycle to sample `start`.
- `frame_len` at maximum (2^LEN_WIDTH−1): the counter compares against `frame_len`−1 and never overflows.

## Structure
- Shared package `axis_pkg`:
  - FSM state encoding (IDLE/SEND/GAP) as localparams/typedef;
  - default widths DATA_WIDTH=32, LEN_WIDTH=12;
  - `frame_cnt` width 16.
- Single module; no sub-module needed. One sequential process covers state, counters and output registers.

## Test plan
- `seed`=0x10, `frame_len`=4, `gap_cycles`=0, ready=1 → data 0x10,0x11,0x12,0x13 on 4 consecutive cycles; last only on 0x13; `done` one cycle later; `frame_cnt`=1.
- Same frame with ready toggling 1,0,0,1,0,1,1,1 → data/last held stable while ready=0; exactly 4 transfers; order and values unchanged.
- `frame_len`=1, `seed`=0xFFFFFFFF → single beat 0xFFFFFFFF with last=1. Second frame `frame_len`=2 from seed 0xFFFFFFFF → 0xFFFFFFFF, 0x00000000.
- `gap_cycles`=3, `start` held high continuously → 3 GAP cycles plus 1 IDLE cycle between frames; `start` during SEND/GAP produces no extra frame; `frame_len`=0 start produces nothing.
- `reset_n` pulsed high at beat 2 of a 6-beat frame → valid/last/busy drop asynchronously; `frame_cnt` stays 0; the next start begins cleanly from seed.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream frame generator: default widths and FSM encoding.
package axis_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 12;
    localparam int DEF_GAP_WIDTH  = 8;
    localparam int FCNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;
endpackage

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame transmitter: emits one incrementing-data frame per start,
// then holds off for a programmable gap. All outputs come straight from registers.
module axis_frame_gen
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int GAP_WIDTH  = DEF_GAP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic                  busy,
    output logic                  done,
    output logic [FCNT_WIDTH-1:0] frame_cnt
);
    state_t                  r_state, w_state_next;
    logic [LEN_WIDTH-1:0]    r_len, w_len_next;
    logic [LEN_WIDTH-1:0]    r_cnt, w_cnt_next;
    logic [GAP_WIDTH-1:0]    r_gap, w_gap_next;
    logic [DATA_WIDTH-1:0]   r_data, w_data_next;
    logic                    r_valid, w_valid_next;
    logic                    r_last, w_last_next;
    logic                    r_busy, w_busy_next;
    logic                    r_done, w_done_next;
    logic [FCNT_WIDTH-1:0]   r_fcnt, w_fcnt_next;
    logic                    w_fire;

    assign w_fire = r_valid && m_axis_ready;

    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_cnt_next   = r_cnt;
        w_gap_next   = r_gap;
        w_data_next  = r_data;
        w_valid_next = r_valid;
        w_last_next  = r_last;
        w_done_next  = 1'b0;
        w_fcnt_next  = r_fcnt;
        case (r_state)
            ST_IDLE: begin
                if (start && (frame_len != '0)) begin
                    w_state_next = ST_SEND;
                    w_len_next   = frame_len;
                    w_gap_next   = gap_cycles;
                    w_data_next  = seed;
                    w_cnt_next   = '0;
                    w_valid_next = 1'b1;
                    w_last_next  = (frame_len == LEN_WIDTH'(1));
                end
            end
            ST_SEND: begin
                if (w_fire) begin
                    if (r_last) begin
                        w_valid_next = 1'b0;
                        w_last_next  = 1'b0;
                        w_done_next  = 1'b1;
                        w_fcnt_next  = r_fcnt + 1'b1;
                        w_state_next = (r_gap != '0) ? ST_GAP : ST_IDLE;
                    end else begin
                        w_cnt_next  = r_cnt + 1'b1;
                        w_data_next = r_data + 1'b1;
                        // Comparing against len-1 keeps the counter below len, so a maximal frame never wraps it.
                        w_last_next = (LEN_WIDTH'(r_cnt + 1'b1) == LEN_WIDTH'(r_len - 1'b1));
                    end
                end
            end
            ST_GAP: begin
                if (r_gap <= GAP_WIDTH'(1)) begin
                    w_gap_next   = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_gap_next = r_gap - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_valid_next = 1'b0;
                w_last_next  = 1'b0;
            end
        endcase
        w_busy_next = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_len   <= w_len_next;
            r_cnt   <= w_cnt_next;
            r_gap   <= w_gap_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_last  <= w_last_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    assign m_axis_data  = r_data;
    assign m_axis_valid = r_valid;
    assign m_axis_last  = r_last;
    assign busy         = r_busy;
    assign done         = r_done;
    assign frame_cnt    = r_fcnt;
endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: per-cycle vector table plus hand sequences for gap, reset and max length.
module tb_axis_frame_gen;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [11:0] frame_len;
    logic [31:0] seed;
    logic [7:0]  gap_cycles;
    logic [31:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic        m_axis_last;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    axis_frame_gen dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .frame_len    (frame_len),
        .seed         (seed),
        .gap_cycles   (gap_cycles),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .busy         (busy),
        .done         (done),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [11:0] len;
        logic [31:0] seed;
        logic [7:0]  gap;
        logic        ready;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic [11:0] l, logic [31:0] sd, logic [7:0] g, logic r,
                                logic v, logic [31:0] d, logic la, logic b, logic dn, logic [15:0] c);
        vec_t t;
        t.start = s; t.len = l; t.seed = sd; t.gap = g; t.ready = r;
        t.valid = v; t.data = d; t.last = la; t.busy = b; t.done = dn; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [31:0] d, input logic la,
                              input logic b, input logic dn, input logic [15:0] c);
        chk({tag, ".valid"}, {31'd0, m_axis_valid}, {31'd0, v});
        if (v) chk({tag, ".data"}, m_axis_data, d);
        chk({tag, ".last"}, {31'd0, m_axis_last}, {31'd0, la});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
        chk({tag, ".frame_cnt"}, {16'd0, frame_cnt}, {16'd0, c});
    endtask

    initial begin
        int n, last_idx, last_hits, guard;
        logic [31:0] last_data;

        reset_n = 1'b1; start = 1'b0; frame_len = '0; seed = '0; gap_cycles = '0; m_axis_ready = 1'b0;
        // basic frame, ready=1
        vecs.push_back(mk(1, 4, 32'h10, 0, 1, 1, 32'h10, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4, 32'h10, 0, 1, 1, 32'h11, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4, 32'h10, 0, 1, 1, 32'h12, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4, 32'h10, 0, 1, 1, 32'h13, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4, 32'h10, 0, 1, 0, 32'h0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 4, 32'h10, 0, 1, 0, 32'h0,  0, 0, 0, 1));
        // same frame, ready 1,0,0,1,0,1,1,1
        vecs.push_back(mk(1, 4, 32'h10, 0, 0, 1, 32'h10, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4, 32'h10, 0, 1, 1, 32'h11, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4, 32'h10, 0, 0, 1, 32'h11, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4, 32'h10, 0, 0, 1, 32'h11, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4, 32'h10, 0, 1, 1, 32'h12, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4, 32'h10, 0, 0, 1, 32'h12, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4, 32'h10, 0, 1, 1, 32'h13, 1, 1, 0, 1));
        vecs.push_back(mk(0, 4, 32'h10, 0, 1, 0, 32'h0,  0, 0, 1, 2));
        vecs.push_back(mk(0, 4, 32'h10, 0, 1, 0, 32'h0,  0, 0, 0, 2));
        // single beat at all-ones, then data wrap to zero
        vecs.push_back(mk(1, 1, 32'hFFFFFFFF, 0, 1, 1, 32'hFFFFFFFF, 1, 1, 0, 2));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 1, 0, 32'h0,        0, 0, 1, 3));
        vecs.push_back(mk(1, 2, 32'hFFFFFFFF, 0, 1, 1, 32'hFFFFFFFF, 0, 1, 0, 3));
        vecs.push_back(mk(0, 2, 32'hFFFFFFFF, 0, 1, 1, 32'h00000000, 1, 1, 0, 3));
        vecs.push_back(mk(0, 2, 32'hFFFFFFFF, 0, 1, 0, 32'h0,        0, 0, 1, 4));
        vecs.push_back(mk(0, 2, 32'hFFFFFFFF, 0, 1, 0, 32'h0,        0, 0, 0, 4));

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 32'h0, 0, 0, 0, 0);
        chk("reset.data", m_axis_data, 32'h0);
        reset_n = 1'b0;

        foreach (vecs[i]) begin
            start = vecs[i].start; frame_len = vecs[i].len; seed = vecs[i].seed;
            gap_cycles = vecs[i].gap; m_axis_ready = vecs[i].ready;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].last,
                       vecs[i].busy, vecs[i].done, vecs[i].cnt);
            $display("vec %0d: start=%0b ready=%0b -> valid=%0b data=0x%08h last=%0b busy=%0b done=%0b cnt=%0d",
                     i, start, m_axis_ready, m_axis_valid, m_axis_data, m_axis_last, busy, done, frame_cnt);
        end

        // gap=3 with start held: 2 beats, 3 GAP cycles, 1 IDLE cycle, repeat
        start = 1'b1; frame_len = 12'd2; seed = 32'h100; gap_cycles = 8'd3; m_axis_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int ph;
            ph = k % 6;
            if (k == 11) start = 1'b0;
            tick();
            check_outs($sformatf("gap%0d", k), ph < 2, 32'h100 + ph, ph == 1, ph < 5, ph == 2,
                       (k < 2) ? 16'd4 : (k < 8) ? 16'd5 : 16'd6);
            $display("gap cycle %0d: valid=%0b busy=%0b done=%0b cnt=%0d", k, m_axis_valid, busy, done, frame_cnt);
        end
        start = 1'b1; frame_len = 12'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outs($sformatf("len0_%0d", k), 0, 32'h0, 0, 0, 0, 6);
            $display("len0 cycle %0d: valid=%0b busy=%0b done=%0b", k, m_axis_valid, busy, done);
        end

        // asynchronous reset during beat 2 of a 6-beat frame
        start = 1'b1; frame_len = 12'd6; seed = 32'h40; gap_cycles = 8'd0; m_axis_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rst.pre_data", m_axis_data, 32'h42);
        #2 reset_n = 1'b1;
        #1;
        check_outs("rst.async", 0, 32'h0, 0, 0, 0, 0);
        $display("async reset: valid=%0b last=%0b busy=%0b cnt=%0d", m_axis_valid, m_axis_last, busy, frame_cnt);
        #1 reset_n = 1'b0;
        tick();
        check_outs("rst.after", 0, 32'h0, 0, 0, 0, 0);
        start = 1'b1; frame_len = 12'd2;
        tick();
        start = 1'b0;
        check_outs("rst.restart0", 1, 32'h40, 0, 1, 0, 0);
        tick();
        check_outs("rst.restart1", 1, 32'h41, 1, 1, 0, 0);
        tick();
        check_outs("rst.restart_done", 0, 32'h0, 0, 0, 1, 1);
        $display("restart after reset: done=%0b cnt=%0d", done, frame_cnt);

        // maximum frame length
        start = 1'b1; frame_len = 12'hFFF; seed = 32'h1000;
        tick();
        start = 1'b0;
        n = 0; last_idx = -1; last_hits = 0; last_data = '0; guard = 0;
        while (!done && guard < 5000) begin
            if (m_axis_valid) begin
                if (m_axis_last) begin
                    last_idx = n; last_data = m_axis_data; last_hits++;
                end
                n++;
            end
            tick();
            guard++;
        end
        chk("max.timeout", {31'd0, guard >= 5000}, 32'd0);
        chk("max.beats", n, 32'd4095);
        chk("max.last_idx", last_idx, 32'd4094);
        chk("max.last_hits", last_hits, 32'd1);
        chk("max.last_data", last_data, 32'h1000 + 32'd4094);
        chk("max.frame_cnt", {16'd0, frame_cnt}, 32'd2);
        $display("max frame: beats=%0d last_idx=%0d last_data=0x%08h cnt=%0d", n, last_idx, last_data, frame_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
